// File: rtl/conv_calc_mc.sv
// Time-multiplexed KxK convolution engine: one channel per cycle, streamed out.
// Optional CONV_CALC_MC_RELU_EN clamps negative results to zero.
module conv_calc_mc #(
   parameter int FILTER_SIZE = 5,
   parameter int OUT_CH      = 3,
   parameter int DATA_BITS   = 8,
   parameter int WEIGHT_BITS = 8,
   parameter int FRAC_BITS   = 8,
   parameter int OUT_BITS    = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] in_data,
   output logic out_valid,
   input  logic out_ready,
   output logic signed [OUT_BITS-1:0] out_data,
   output logic [(OUT_CH>1 ? $clog2(OUT_CH) : 1)-1:0] out_ch,
   output logic out_last,
   input  logic wr_en,
   input  logic [$clog2(OUT_CH*FILTER_SIZE*FILTER_SIZE+OUT_CH)-1:0] wr_addr,
   input  logic signed [WEIGHT_BITS-1:0] wr_data,
   output logic wr_err
);

   localparam int KK    = FILTER_SIZE * FILTER_SIZE;
   localparam int DEPTH = OUT_CH * KK + OUT_CH;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
   localparam int PW    = DATA_BITS + WEIGHT_BITS + 1;
   localparam int ACCW  = DATA_BITS + WEIGHT_BITS + $clog2(KK) + 1;
   localparam int SW    = ACCW + 1;
   localparam logic [CW-1:0] LAST = CW'(OUT_CH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t state_q, state_d;
   logic [CW-1:0] ch_q;
   logic [KK*DATA_BITS-1:0] win_q;
   logic signed [WEIGHT_BITS-1:0] mem [DEPTH];

   logic load, accept, wr_ok;
   logic signed [DATA_BITS:0] px;
   logic signed [WEIGHT_BITS-1:0] wv, bias;
   logic signed [PW-1:0] prod;
   logic signed [ACCW-1:0] acc, sh;
   logic signed [SW-1:0] sum;
   logic [SW-OUT_BITS:0] hi;
   logic signed [OUT_BITS-1:0] res;

   assign wr_ok = ({1'b0, wr_addr} < (AW+1)'(DEPTH));

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      load     = 1'b0;
      accept   = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            load = !out_valid || out_ready;
            if (load && ch_q == LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Shared dot-product unit, steered by the channel counter
   always_comb begin
      acc  = '0;
      px   = '0;
      wv   = '0;
      prod = '0;
      for (int i = 0; i < KK; i++) begin
         px   = {1'b0, win_q[i*DATA_BITS +: DATA_BITS]};
         wv   = mem[AW'(int'(ch_q) * KK + i)];
         prod = PW'(px) * PW'(wv);
         acc  = acc + {{(ACCW-PW){prod[PW-1]}}, prod};
      end
      sh   = acc >>> FRAC_BITS;
      bias = mem[AW'(OUT_CH * KK + int'(ch_q))];
      sum  = {sh[ACCW-1], sh}
           + {{(SW-WEIGHT_BITS){bias[WEIGHT_BITS-1]}}, bias};
      hi   = sum[SW-1:OUT_BITS-1];
      if (&hi || ~|hi)
         res = sum[OUT_BITS-1:0];
      else if (sum[SW-1])
         res = {1'b1, {(OUT_BITS-1){1'b0}}};
      else
         res = {1'b0, {(OUT_BITS-1){1'b1}}};
`ifdef CONV_CALC_MC_RELU_EN
      if (res[OUT_BITS-1]) res = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_err  <= wr_en && (state_q == RUN || !wr_ok);
         if (accept) ch_q <= '0;
         if (load) begin
            out_data  <= res;
            out_ch    <= ch_q;
            out_last  <= (ch_q == LAST);
            out_valid <= 1'b1;
            ch_q      <= (ch_q == LAST) ? '0 : ch_q + 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Window and coefficient storage carry no reset
   always_ff @(posedge clk) begin
      if (accept) win_q <= in_data;
      if (state_q == IDLE && wr_en && wr_ok) mem[wr_addr] <= wr_data;
   end

endmodule

// File: tb/tb_conv_calc_mc.sv
// Directed bench for conv_calc_mc: vector table plus multi-cycle sequences.
// Build with CONV_CALC_MC_RELU_EN to check the clamped variant.
module tb_conv_calc_mc;

   localparam int KK = 25;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready, out_last;
   logic wr_en, wr_err;
   logic [KK*8-1:0] in_data;
   logic signed [11:0] out_data;
   logic [1:0] out_ch;
   logic [6:0] wr_addr;
   logic signed [7:0] wr_data;

   conv_calc_mc dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ch(out_ch), .out_last(out_last),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int data;
      int ch;
      int last;
      int cyc;
   } obs_t;
   obs_t q[$];

   always @(negedge clk)
      if (out_valid && out_ready)
         q.push_back('{int'(out_data), int'(out_ch), int'(out_last), cyc});

   int errors = 0;
   int checks = 0;

   task automatic chk(string nm, int act, int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      end
   endtask

   function automatic int relu(int x);
`ifdef CONV_CALC_MC_RELU_EN
      return (x < 0) ? 0 : x;
`else
      return x;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(int a, int d);
      wr_en   = 1'b1;
      wr_addr = 7'(a);
      wr_data = 8'(d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic send(logic [7:0] p, output int acc);
      int n;
      n        = 0;
      in_data  = {KK{p}};
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      acc = cyc;
      if (n >= 50) chk("accept_timeout", n, 0);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_q(int n);
      int t;
      t = 0;
      while (q.size() < n && t < 60) begin
         tick();
         t++;
      end
      if (q.size() < n) chk("output_timeout", q.size(), n);
   endtask

   task automatic expect_win(string nm, int acc, bit timed,
                             int e0, int e1, int e2);
      int e[3];
      obs_t o;
      e = '{e0, e1, e2};
      wait_q(3);
      for (int c = 0; c < 3; c++) begin
         if (q.size() == 0) return;
         o = q.pop_front();
         chk($sformatf("%s_ch%0d_data", nm, c), o.data, relu(e[c]));
         chk($sformatf("%s_ch%0d_idx", nm, c), o.ch, c);
         chk($sformatf("%s_ch%0d_last", nm, c), o.last, (c == 2) ? 1 : 0);
         if (timed)
            chk($sformatf("%s_ch%0d_cycle", nm, c), o.cyc, acc + 2 + c);
      end
   endtask

   typedef struct {
      logic [7:0] pix;
      int e0;
      int e1;
      int e2;
   } vec_t;
   vec_t vt[5];

   initial begin
      int a, a2;
      vt[0] = '{8'd255, 24, -20, 2047};
      vt[1] = '{8'd0, 0, 5, -128};
      vt[2] = '{8'd1, 0, 4, -116};
      vt[3] = '{8'd100, 9, -5, 1112};
      vt[4] = '{8'd20, 1, 3, 120};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_wr_err", wr_err, 0);
      q.delete();

      for (int c = 0; c < 3; c++)
         for (int t = 0; t < KK; t++)
            wr(c * KK + t, (c == 0) ? 1 : (c == 1) ? -1 : 127);
      wr(75, 0);
      wr(76, 5);
      wr(77, -128);
      chk("wr_err_idle", wr_err, 0);

      for (int v = 0; v < 5; v++) begin
         send(vt[v].pix, a);
         tick();
         tick();
         chk($sformatf("vec%0d_in_ready_busy", v), in_ready, 0);
         tick();
         chk($sformatf("vec%0d_in_ready_back", v), in_ready, 1);
         expect_win($sformatf("vec%0d", v), a, 1'b1,
                    vt[v].e0, vt[v].e1, vt[v].e2);
      end

      out_ready = 1'b0;
      send(8'd255, a);
      tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp%0d_valid", k), out_valid, 1);
         chk($sformatf("bp%0d_data", k), int'(out_data), relu(24));
         chk($sformatf("bp%0d_ch", k), out_ch, 0);
         tick();
      end
      out_ready = 1'b1;
      expect_win("bp", a, 1'b0, 24, -20, 2047);
      repeat (4) tick();
      chk("bp_no_dup", q.size(), 0);

      send(8'd255, a);
      send(8'd0, a2);
      chk("b2b_accept_gap", a2 - a, 4);
      wait_q(6);
      expect_win("b2b_w0", a, 1'b1, 24, -20, 2047);
      expect_win("b2b_w1", a2, 1'b1, 0, 5, -128);

      send(8'd255, a);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      q.delete();
      send(8'd255, a);
      expect_win("post_rst", a, 1'b1, 24, -20, 2047);

      send(8'd255, a);
      wr_en = 1'b1; wr_addr = 7'd0; wr_data = 8'sd2;
      tick();
      wr_en = 1'b0;
      chk("run_wr_err_pulse", wr_err, 1);
      tick();
      chk("run_wr_err_clear", wr_err, 0);
      expect_win("run_wr", a, 1'b1, 24, -20, 2047);
      send(8'd255, a);
      expect_win("after_run_wr", a, 1'b1, 24, -20, 2047);

      wr(78, 5);
      chk("oob_wr_err_pulse", wr_err, 1);
      tick();
      chk("oob_wr_err_clear", wr_err, 0);

      for (int t = 0; t < KK; t++) wr(t, 2);
      chk("idle_wr_err", wr_err, 0);
      send(8'd255, a);
      expect_win("w2", a, 1'b1, 49, -20, 2047);

      wr_en = 1'b1; wr_addr = 7'd75; wr_data = 8'sd10;
      send(8'd255, a);
      wr_en = 1'b0;
      expect_win("wr_accept", a, 1'b1, 59, -20, 2047);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
